// File: rtl/data_sram_resp.sv
// Word-wide SRAM with byte-lane writes and a configurable number of wait states.
// Requests are latched on acceptance; the access completes on the edge entering DONE.
module data_sram_resp #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, stateNext;
  logic [3:0]        cnt, cntNext;
  logic [ADDR_W-1:0] idxQ;
  logic [3:0]        wenQ;
  logic [31:0]       wdataQ;
  logic [ADDR_W-1:0] reqIdx;
  logic [3:0]        reqWen;
  logic [31:0]       reqWdata;
  logic              accept, commit;
  logic [31:0]       mem [2**ADDR_W];
  logic              unusedAddr;

  assign unusedAddr = ^{addr[31:ADDR_W+2], addr[1:0]};

  // With WAIT=0 the commit coincides with acceptance, so take the live request then.
  assign reqIdx   = (state == IDLE) ? addr[ADDR_W+1:2] : idxQ;
  assign reqWen   = (state == IDLE) ? wen              : wenQ;
  assign reqWdata = (state == IDLE) ? wdata            : wdataQ;

  assign busy = en & (state != DONE) & ~rst;

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          accept = 1'b1;
          if (WAIT == 0) begin
            stateNext = DONE;
            commit    = 1'b1;
          end else begin
            stateNext = BUSY;
            cntNext   = 4'(WAIT - 1);
          end
        end
      end
      BUSY: begin
        if (!en) begin
          stateNext = IDLE;
        end else if (cnt == '0) begin
          stateNext = DONE;
          commit    = 1'b1;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rdata  <= '0;
      idxQ   <= '0;
      wenQ   <= '0;
      wdataQ <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (accept) begin
        idxQ   <= addr[ADDR_W+1:2];
        wenQ   <= wen;
        wdataQ <= wdata;
      end
      if (commit && reqWen == 4'b0000) rdata <= mem[reqIdx];
    end
  end

  // Array has no reset; a reset during BUSY suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (reqWen[i]) mem[reqIdx][8*i +: 8] <= reqWdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed and randomized checks of data_sram_resp with WAIT=2 and WAIT=0 instances
// against a word-array reference model.
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        en2, en0;
  logic [3:0]  wen2, wen0;
  logic [31:0] addr2, addr0, wdata2, wdata0;
  logic [31:0] rdata2, rdata0;
  logic        busy2, busy0;

  int total = 0;
  int bad   = 0;

  logic [31:0] memModel [2][1024];
  logic [31:0] rdModel  [2];

  always #5 clk = ~clk;

  data_sram_resp #(.ADDR_W(10), .WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .wen(wen2), .addr(addr2),
    .wdata(wdata2), .rdata(rdata2), .busy(busy2)
  );

  data_sram_resp #(.ADDR_W(10), .WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .wen(wen0), .addr(addr0),
    .wdata(wdata0), .rdata(rdata0), .busy(busy0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int z, input logic e, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] d);
    if (z == 1) begin
      en0 = e; wen0 = w; addr0 = a; wdata0 = d;
    end else begin
      en2 = e; wen2 = w; addr2 = a; wdata2 = d;
    end
  endtask

  function automatic logic [31:0] busyOf(input int z);
    return (z == 1) ? {31'b0, busy0} : {31'b0, busy2};
  endfunction

  function automatic logic [31:0] rdataOf(input int z);
    return (z == 1) ? rdata0 : rdata2;
  endfunction

  // One complete access; z=1 selects the WAIT=0 instance. en stays high through DONE.
  task automatic access(input int z, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int unsigned waits = (z == 1) ? 0 : 2;
    int unsigned idx   = 32'(a[11:2]);
    @(negedge clk);
    drive(z, 1'b1, w, a, d);
    #1 check({tag, ".busyAccept"}, busyOf(z), 32'd1);
    for (int unsigned k = 1; k <= waits; k++) begin
      @(negedge clk);
      #1 check({tag, ".busyWait"}, busyOf(z), 32'd1);
    end
    if (w == 4'b0000) begin
      rdModel[z] = memModel[z][idx];
    end else begin
      for (int b = 0; b < 4; b++)
        if (w[b]) memModel[z][idx][8*b +: 8] = d[8*b +: 8];
    end
    @(negedge clk);
    #1;
    check({tag, ".busyDone"}, busyOf(z), 32'd0);
    check({tag, ".rdata"}, rdataOf(z), rdModel[z]);
  endtask

  initial begin
    logic [31:0] a, d, hi;
    logic [3:0]  w;
    int unsigned sel;

    rst = 1'b1;
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    drive(0, 1'b1, 4'hF, 32'h10, 32'h1);
    drive(1, 1'b1, 4'hF, 32'h10, 32'h1);
    #1;
    check("rst.busy2", busyOf(0), 32'd0);
    check("rst.busy0", busyOf(1), 32'd0);
    check("rst.rdata2", rdata2, 32'h0);
    check("rst.rdata0", rdata0, 32'h0);
    rdModel[0] = '0;
    rdModel[1] = '0;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 4'h0, 32'h0, 32'h0);

    // basic write then read
    access(0, 4'hF, 32'h10, 32'hDEADBEEF, "wr10");
    access(0, 4'h0, 32'h10, 32'h0, "rd10");
    check("rd10.value", rdata2, 32'hDEADBEEF);

    // byte lane merge and ignored low address bits
    access(0, 4'hF, 32'h20, 32'h11223344, "wr20");
    access(0, 4'b0010, 32'h20, 32'h0000AB00, "lane20");
    access(0, 4'h0, 32'h20, 32'h0, "rd20");
    check("rd20.value", rdata2, 32'h1122AB44);
    access(0, 4'h0, 32'h23, 32'h0, "rd23");
    check("rd23.value", rdata2, 32'h1122AB44);

    // aliasing above ADDR_W
    access(0, 4'hF, 32'h1010, 32'hCAFEF00D, "wr1010");
    access(0, 4'h0, 32'h0010, 32'h0, "rdAlias");
    check("rdAlias.value", rdata2, 32'hCAFEF00D);

    // cancel after one BUSY cycle
    access(0, 4'hF, 32'h30, 32'h12345678, "wr30");
    @(negedge clk);
    drive(0, 1'b1, 4'hF, 32'h30, 32'hFFFFFFFF);
    #1 check("cancel.busyAccept", busyOf(0), 32'd1);
    @(negedge clk);
    #1 check("cancel.busyWait", busyOf(0), 32'd1);
    @(negedge clk);
    drive(0, 1'b0, 4'hF, 32'h30, 32'hFFFFFFFF);
    #1 check("cancel.busyDrop", busyOf(0), 32'd0);
    @(negedge clk);
    #1 check("cancel.rdataHeld", rdata2, rdModel[0]);
    access(0, 4'h0, 32'h30, 32'h0, "rd30");
    check("rd30.value", rdata2, 32'h12345678);

    // reset during BUSY aborts the write
    access(0, 4'hF, 32'h40, 32'h0, "wr40");
    access(0, 4'h0, 32'h10, 32'h0, "rd10b");
    @(negedge clk);
    drive(0, 1'b1, 4'hF, 32'h40, 32'hAAAA5555);
    #1 check("rstMid.busyAccept", busyOf(0), 32'd1);
    @(negedge clk);
    #1 check("rstMid.busyWait", busyOf(0), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rstMid.busyInRst", busyOf(0), 32'd0);
    @(negedge clk);
    #1;
    check("rstMid.busyInRst2", busyOf(0), 32'd0);
    check("rstMid.rdata2", rdata2, 32'h0);
    check("rstMid.rdata0", rdata0, 32'h0);
    rdModel[0] = '0;
    rdModel[1] = '0;
    rst = 1'b0;
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    access(0, 4'h0, 32'h40, 32'h0, "rd40");
    check("rd40.value", rdata2, 32'h0);

    // zero wait states, back-to-back with en held high
    access(1, 4'hF, 32'h60, 32'h01020304, "z.init");
    access(1, 4'h0, 32'h60, 32'h0, "z.rd1");
    access(1, 4'hF, 32'h60, 32'hA5A5A5A5, "z.wr");
    access(1, 4'h0, 32'h60, 32'h0, "z.rd2");
    check("z.rd2.value", rdata0, 32'hA5A5A5A5);
    drive(1, 1'b0, 4'h0, 32'h0, 32'h0);

    // randomized traffic over a small set of words on both instances
    for (int z = 0; z < 2; z++) begin
      for (int unsigned k = 0; k < 8; k++)
        access(z, 4'hF, 32'h140 + 4 * k, $urandom, "rnd.init");
      for (int n = 0; n < 30; n++) begin
        sel = $urandom_range(7, 0);
        hi  = $urandom;
        a   = {hi[31:12], 10'(32'h50 + sel), hi[1:0]};
        d   = $urandom;
        w   = ($urandom_range(2, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
        access(z, w, a, d, "rnd");
      end
      drive(z, 1'b0, 4'h0, 32'h0, 32'h0);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
